// File: rtl/fse_lms_ctrl_if.sv
// fse_lms_ctrl_if: control/status bundle between the LMS adaptation controller
// and its user (equalizer top / testbench).
//   master : drives run/freeze and the symbol-rate slicer error, observes status
//   slave  : the controller itself
// Signals:
//   i_run, i_freeze, i_err[NBerr], i_err_valid        -> controller
//   o_sym_strobe, o_upd_en, o_mu_sh[3], o_mode,
//   o_state[2], o_coeff_clr, o_locked                 <- controller
interface fse_lms_ctrl_if #(
  parameter int NBerr = 8
);
  logic                    i_run;
  logic                    i_freeze;
  logic signed [NBerr-1:0] i_err;
  logic                    i_err_valid;
  logic                    o_sym_strobe;
  logic                    o_upd_en;
  logic [2:0]              o_mu_sh;
  logic                    o_mode;
  logic [1:0]              o_state;
  logic                    o_coeff_clr;
  logic                    o_locked;

  modport master (
    output i_run, i_freeze, i_err, i_err_valid,
    input  o_sym_strobe, o_upd_en, o_mu_sh, o_mode, o_state, o_coeff_clr, o_locked
  );

  modport slave (
    input  i_run, i_freeze, i_err, i_err_valid,
    output o_sym_strobe, o_upd_en, o_mu_sh, o_mode, o_state, o_coeff_clr, o_locked
  );
endinterface

// File: rtl/fse_lms_ctrl.sv
// fse_lms_ctrl: adaptation controller for the fractionally-spaced LMS equalizer.
// Generates the symbol-phase strobe and coefficient-update enable, selects mu
// (right shift) and training vs decision-directed mode, and watches windowed
// |slicer error| to declare lock / loss and to restart acquisition.
// Ports:
//   clkA  : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : fse_lms_ctrl_if.slave (run/freeze/error in, strobe/enable/mu/mode/state out)
module fse_lms_ctrl #(
  parameter int NBerr       = 8,
  parameter int OS          = 2,
  parameter int LOG2_WIN    = 6,
  parameter int TH_LOCK     = 256,
  parameter int TH_LOSS     = 1024,
  parameter int MU_ACQ      = 2,
  parameter int MU_TRK      = 5,
  parameter int MAX_ACQ_WIN = 16
) (
  input  logic           clkA,
  input  logic           reset,
  fse_lms_ctrl_if.slave  bus
);
  // accumulator holds up to WIN * (2^(NBerr-1)-1), so it never overflows
  localparam int W  = NBerr - 1 + LOG2_WIN;
  localparam int PW = (OS > 1) ? $clog2(OS) : 1;
  localparam int AW = $clog2(MAX_ACQ_WIN + 1);

  localparam logic [PW-1:0]       PH_LAST  = PW'(OS - 1);
  localparam logic [LOG2_WIN-1:0] WIN_LAST = '1;
  localparam logic [W:0]          TH_LK    = (W+1)'(TH_LOCK);
  localparam logic [W:0]          TH_LS    = (W+1)'(TH_LOSS);
  localparam logic [AW-1:0]       ACQ_LAST = AW'(MAX_ACQ_WIN - 1);
  localparam logic [2:0]          MU_A     = 3'(MU_ACQ);
  localparam logic [2:0]          MU_T     = 3'(MU_TRK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACQ   = 2'b01,
    S_TRACK = 2'b10,
    S_HOLD  = 2'b11
  } st_t;

  st_t                 state_q, state_d, saved_q, saved_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [LOG2_WIN-1:0] win_q, win_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [1:0]          lock_q, lock_d;
  logic [AW-1:0]       acqw_q, acqw_d;
  logic                clr_q, clr_d;

  // |err| with the most-negative code saturated to the max positive magnitude
  logic signed [NBerr-1:0] neg;
  logic [NBerr-2:0]        mag;
  logic [W:0]              sum;

  always_comb begin
    neg = -bus.i_err;
    if (bus.i_err == {1'b1, {(NBerr-1){1'b0}}}) mag = '1;
    else if (bus.i_err[NBerr-1])                mag = neg[NBerr-2:0];
    else                                        mag = bus.i_err[NBerr-2:0];
    sum = {1'b0, acc_q} + {{(LOG2_WIN+1){1'b0}}, mag};
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    phase_d = (state_q == S_IDLE) ? '0 : ((phase_q == PH_LAST) ? '0 : phase_q + 1'b1);
    win_d   = win_q;
    acc_d   = acc_q;
    lock_d  = lock_q;
    acqw_d  = acqw_q;
    clr_d   = 1'b0;

    if (!bus.i_run) begin
      state_d = S_IDLE;
      phase_d = '0;
      win_d   = '0;
      acc_d   = '0;
      lock_d  = '0;
      acqw_d  = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_ACQ;
      clr_d   = 1'b1;
      lock_d  = '0;
      acqw_d  = '0;
    end else if (state_q == S_HOLD) begin
      // window contents are frozen; just wait for release
      if (!bus.i_freeze) state_d = saved_q;
    end else if (bus.i_freeze) begin
      state_d = S_HOLD;
      saved_d = state_q;
    end else if (bus.i_err_valid) begin
      win_d = win_q + 1'b1;
      if (win_q != WIN_LAST) begin
        acc_d = acc_q + {{LOG2_WIN{1'b0}}, mag};
      end else begin
        acc_d = '0;
        if (state_q == S_ACQ) begin
          if (sum < TH_LK) begin
            lock_d = lock_q + 2'd1;
            if (lock_q == 2'd1) state_d = S_TRACK;
          end else begin
            lock_d = '0;
            // too long without lock: re-seed coefficients and keep acquiring
            if (acqw_q == ACQ_LAST) begin
              acqw_d = '0;
              clr_d  = 1'b1;
            end else begin
              acqw_d = acqw_q + 1'b1;
            end
          end
        end else if (sum > TH_LS) begin
          state_d = S_ACQ;
          lock_d  = '0;
          acqw_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clkA) begin
    if (!reset) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      phase_q <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      lock_q  <= '0;
      acqw_q  <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      phase_q <= phase_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      lock_q  <= lock_d;
      acqw_q  <= acqw_d;
      clr_q   <= clr_d;
    end
  end

  // HOLD reports whatever the frozen state reported
  logic trk;
  assign trk = (state_q == S_TRACK) || (state_q == S_HOLD && saved_q == S_TRACK);

  assign bus.o_sym_strobe = (phase_q == '0) && (state_q != S_IDLE);
  assign bus.o_upd_en     = bus.o_sym_strobe && (state_q == S_ACQ || state_q == S_TRACK);
  assign bus.o_mu_sh      = trk ? MU_T : MU_A;
  assign bus.o_mode       = trk;
  assign bus.o_locked     = trk;
  assign bus.o_state      = state_q;
  assign bus.o_coeff_clr  = clr_q;
endmodule
